led_pio_arbiter: RTL and testbench
==================================

LED_PIO_ARBITER -- requirements
Module: led_pio_arbiter

Interface
REQ-001 Parameter ADDR_W SHALL default to 2; it is the slave word-address width.
REQ-002 Parameter DATA_W SHALL default to 32; it is the data width.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 m0_address  in  ADDR_W  master 0 word address.
REQ-006 m0_chipselect  in  1  master 0 request.
REQ-007 m0_write_n  in  1  master 0 direction: low = write, high = read.
REQ-008 m0_writedata  in  DATA_W  master 0 write data.
REQ-009 m0_readdata  out  DATA_W  master 0 read data; valid when m0_waitrequest is low.
REQ-010 m0_waitrequest  out  1  master 0 stall.
REQ-011 m0_lock  in  1  master 0 grant hold; used only with LED_ARB_LOCK_EN.
REQ-012 m1_address, m1_chipselect, m1_write_n, m1_writedata, m1_readdata, m1_waitrequest and m1_lock SHALL mirror the m0_* ports for master 1.
REQ-013 s_address  out  ADDR_W  to the PIO slave.
REQ-014 s_chipselect  out  1  to the PIO slave; the slave has zero wait states and zero read latency.
REQ-015 s_write_n  out  1  to the PIO slave.
REQ-016 s_writedata  out  DATA_W  to the PIO slave.
REQ-017 s_readdata  in  DATA_W  from the PIO slave.

Function
REQ-018 The arbiter SHALL use a registered FSM with states IDLE, GNT0 and GNT1, plus a last_gnt flag.
REQ-019 In IDLE, next state SHALL be:
- only m0_chipselect high -> GNT0;
- only m1_chipselect high -> GNT1;
- both high -> the master other than last_gnt;
- neither high -> IDLE.
REQ-020 A request first seen in IDLE SHALL see waitrequest high for at least one cycle; the access occurs in the following GNTx cycle.
REQ-021 In GNTx, s_* SHALL be driven combinationally from mx_*, and mx_waitrequest SHALL be low; the transaction completes in that cycle, and last_gnt SHALL be set to x at the clock edge.
REQ-022 mx_waitrequest SHALL be high in every cycle in which the FSM is not in GNTx.
REQ-023 mx_readdata SHALL equal s_readdata in GNTx and SHALL be 0 otherwise.
REQ-024 In IDLE, the outputs SHALL be s_chipselect=0, s_write_n=1, s_address=0 and s_writedata=0.
REQ-025 Leaving GNTx without lock: the FSM SHALL go to GNTy if my_chipselect is high, otherwise to IDLE; mx_chipselect is ignored for this decision.
REQ-026 Throughput SHALL be one access per cycle with both masters requesting (strict alternation) and one access per 2 cycles with a single master; no master SHALL wait more than 2 cycles (without lock).
REQ-027 If mx_chipselect is low while in GNTx, s_chipselect SHALL be 0, no slave access SHALL occur, and the FSM SHALL still follow the exit rules.

Reset
REQ-028 While reset_n is low, the design SHALL hold: state=IDLE, last_gnt=1 (m0 wins the first tie), both waitrequests=1, both readdata=0, s_chipselect=0 and s_write_n=1.
REQ-029 A reset asserted mid-access SHALL abort the access immediately (asynchronously), with no slave write after assertion.

Configuration
REQ-030 With LED_ARB_LOCK_EN defined, a GNTx cycle with mx_lock high SHALL go next to GNTx regardless of the other master, and each GNTx cycle with mx_chipselect high SHALL be an access.
REQ-031 With LED_ARB_LOCK_EN defined, dropping mx_lock SHALL restore the REQ-025 exit rules at that edge.
REQ-032 Without LED_ARB_LOCK_EN, the m0_lock/m1_lock ports SHALL remain present, SHALL be ignored, and no lock logic SHALL be synthesised.

Structure
REQ-033 Package led_pio_arb_pkg SHALL hold the arb_state_t enum (IDLE, GNT0, GNT1) and the ADDR_W/DATA_W default localparams.
REQ-034 The design SHALL be a single module with no sub-module; the slave-side mux SHALL be inline.

Verification
REQ-035 Release reset with no requests -> s_chipselect=0, both waitrequests=1, readdata=0 for 10 cycles.
REQ-036 m0 writes 0x1 to address 0 alone -> one cycle later s_chipselect=1, s_write_n=0, s_writedata=0x1 and m0_waitrequest=0 for one cycle; the PIO data register reads 1.
REQ-037 After reset, m0 writes 0x1 and m1 reads address 0 in the same cycle -> GNT0 then GNT1 back-to-back, and m1_readdata=0x1.
REQ-038 Both masters issue 6 accesses each continuously -> grants strictly alternate, one slave access per cycle, and no stall exceeds 2 cycles.
REQ-039 LED_ARB_LOCK_EN defined, m1 holds lock across writes 0x0, 0x1, 0x0 while m0 waits -> m0_waitrequest stays high until lock drops, then m0 is granted next; without the macro the grants alternate.
REQ-040 reset_n pulsed low during a GNT1 write of 0x1 -> s_chipselect=0 immediately and the PIO register keeps its prior value.

Source files
------------

// File: rtl/led_pio_arb_pkg.sv
// Shared types and default widths for the two-master LED PIO arbiter.
package led_pio_arb_pkg;

    localparam int LED_ARB_ADDR_W = 2;
    localparam int LED_ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/led_pio_arbiter.sv
// Two-master round-robin arbiter in front of a zero-wait-state PIO slave.
// Define LED_ARB_LOCK_EN to let a granted master hold the slave with mx_lock.
module led_pio_arbiter
    import led_pio_arb_pkg::*;
#(
    parameter int ADDR_W = LED_ARB_ADDR_W,
    parameter int DATA_W = LED_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic              m0_lock,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    input  logic              m1_lock,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    arb_state_t state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // 1 = master 1 was granted last
    logic       hold0, hold1;

`ifdef LED_ARB_LOCK_EN
    assign hold0 = m0_lock;
    assign hold1 = m1_lock;
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Exit from a grant looks only at the other master, which bounds its wait.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_chipselect && m1_chipselect)
                    state_d = last_gnt_q ? GNT0 : GNT1;
                else if (m0_chipselect)
                    state_d = GNT0;
                else if (m1_chipselect)
                    state_d = GNT1;
                else
                    state_d = IDLE;
            end
            GNT0: begin
                last_gnt_d = 1'b0;
                if (hold0)
                    state_d = GNT0;
                else if (m1_chipselect)
                    state_d = GNT1;
                else
                    state_d = IDLE;
            end
            GNT1: begin
                last_gnt_d = 1'b1;
                if (hold1)
                    state_d = GNT1;
                else if (m0_chipselect)
                    state_d = GNT0;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux; the slave answers in the same cycle, so readdata is passed straight through.
    always_comb begin
        s_chipselect   = 1'b0;
        s_write_n      = 1'b1;
        s_address      = '0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        case (state_q)
            GNT0: begin
                s_chipselect   = m0_chipselect;
                s_write_n      = m0_write_n;
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                m0_waitrequest = 1'b0;
                m0_readdata    = s_readdata;
            end
            GNT1: begin
                s_chipselect   = m1_chipselect;
                s_write_n      = m1_write_n;
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                m1_waitrequest = 1'b0;
                m1_readdata    = s_readdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Directed bench for led_pio_arbiter with a behavioural PIO data register at address 0.
module tb_led_pio_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  m0_address, m1_address, s_address;
    logic        m0_chipselect, m1_chipselect, s_chipselect;
    logic        m0_write_n, m1_write_n, s_write_n;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic        m0_lock, m1_lock;

    logic        pio_clr;
    logic [31:0] pio_q;

    int tests_run;
    int tests_failed;

    led_pio_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_address     (m0_address),
        .m0_chipselect  (m0_chipselect),
        .m0_write_n     (m0_write_n),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m0_lock        (m0_lock),
        .m1_address     (m1_address),
        .m1_chipselect  (m1_chipselect),
        .m1_write_n     (m1_write_n),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .m1_lock        (m1_lock),
        .s_address      (s_address),
        .s_chipselect   (s_chipselect),
        .s_write_n      (s_write_n),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Zero-wait, zero-latency PIO slave; deliberately not cleared by reset_n.
    always @(posedge clk) begin
        if (pio_clr)
            pio_q <= 32'h0;
        else if (s_chipselect && !s_write_n && s_address == 2'd0)
            pio_q <= s_writedata;
    end
    assign s_readdata = (s_address == 2'd0) ? pio_q : 32'h0;

    task automatic idle_inputs();
        m0_chipselect = 1'b0; m0_write_n = 1'b1; m0_address = 2'd0; m0_writedata = 32'h0; m0_lock = 1'b0;
        m1_chipselect = 1'b0; m1_write_n = 1'b1; m1_address = 2'd0; m1_writedata = 32'h0; m1_lock = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pio_clr = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({m0_waitrequest, m1_waitrequest, s_chipselect, s_write_n} !== 4'b1101) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b want=1101", {m0_waitrequest, m1_waitrequest, s_chipselect, s_write_n});
        end
        tests_run++;
        if ({m0_readdata, m1_readdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata got=%h want=0", {m0_readdata, m1_readdata});
        end
        @(negedge clk);
        reset_n = 1'b1;
        pio_clr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if ({s_chipselect, m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata} !== {3'b011, 64'h0}) begin
                tests_failed++;
                $display("FAIL idle_after_reset cycle=%0d cs=%b w0=%b w1=%b rd0=%h rd1=%h want cs=0 w=11 rd=0",
                         c, s_chipselect, m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata);
            end
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_single_write();
        @(negedge clk);
        m0_chipselect = 1'b1; m0_write_n = 1'b0; m0_address = 2'd0; m0_writedata = 32'h1;
        #1;
        tests_run++;
        if ({m0_waitrequest, s_chipselect, s_address, s_writedata} !== {1'b1, 1'b0, 2'd0, 32'h0}) begin
            tests_failed++;
            $display("FAIL sw_idle w0=%b cs=%b addr=%h wd=%h want w0=1 cs=0 addr=0 wd=0",
                     m0_waitrequest, s_chipselect, s_address, s_writedata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({s_chipselect, s_write_n, s_writedata, m0_waitrequest, m1_waitrequest} !== {2'b10, 32'h1, 2'b01}) begin
            tests_failed++;
            $display("FAIL sw_grant cs=%b wn=%b wd=%h w0=%b w1=%b want cs=1 wn=0 wd=1 w0=0 w1=1",
                     s_chipselect, s_write_n, s_writedata, m0_waitrequest, m1_waitrequest);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if ({s_chipselect, m0_waitrequest, pio_q} !== {2'b01, 32'h1}) begin
            tests_failed++;
            $display("FAIL sw_after cs=%b w0=%b pio=%h want cs=0 w0=1 pio=1", s_chipselect, m0_waitrequest, pio_q);
        end
        @(negedge clk);
        m0_chipselect = 1'b1; m0_write_n = 1'b1; m0_address = 2'd0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({m0_waitrequest, m0_readdata} !== {1'b0, 32'h1}) begin
            tests_failed++;
            $display("FAIL sw_readback w0=%b rd0=%h want w0=0 rd0=1", m0_waitrequest, m0_readdata);
        end
        @(negedge clk);
        idle_inputs();
        $display("[TB] single_write: m0 wrote 1, read back %h", m0_readdata);
    endtask

    task automatic test_grant_no_cs();
        @(negedge clk);
        m0_chipselect = 1'b1; m0_write_n = 1'b0; m0_address = 2'd0; m0_writedata = 32'h7;
        @(negedge clk);
        m0_chipselect = 1'b0;
        #1;
        tests_run++;
        if ({s_chipselect, m0_waitrequest} !== 2'b00) begin
            tests_failed++;
            $display("FAIL nocs_grant cs=%b w0=%b want cs=0 w0=0", s_chipselect, m0_waitrequest);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if ({m0_waitrequest, pio_q} !== {1'b1, 32'h1}) begin
            tests_failed++;
            $display("FAIL nocs_after w0=%b pio=%h want w0=1 pio=1", m0_waitrequest, pio_q);
        end
        $display("[TB] grant_no_cs: done");
    endtask

    // last_gnt is now m0, so a tie must go to m1 first.
    task automatic test_tie_last_gnt();
        @(negedge clk);
        m0_chipselect = 1'b1; m0_write_n = 1'b1; m0_address = 2'd0;
        m1_chipselect = 1'b1; m1_write_n = 1'b1; m1_address = 2'd0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({m0_waitrequest, m1_waitrequest, m1_readdata} !== {2'b10, 32'h1}) begin
            tests_failed++;
            $display("FAIL tie_m1_first w0=%b w1=%b rd1=%h want w0=1 w1=0 rd1=1", m0_waitrequest, m1_waitrequest, m1_readdata);
        end
        @(negedge clk);
        m1_chipselect = 1'b0;
        #1;
        tests_run++;
        if ({m0_waitrequest, m1_waitrequest, m0_readdata} !== {2'b01, 32'h1}) begin
            tests_failed++;
            $display("FAIL tie_m0_second w0=%b w1=%b rd0=%h want w0=0 w1=1 rd0=1", m0_waitrequest, m1_waitrequest, m0_readdata);
        end
        @(negedge clk);
        idle_inputs();
        $display("[TB] tie_last_gnt: done");
    endtask

    task automatic test_reset_tie();
        @(negedge clk);
        reset_n = 1'b0;
        pio_clr = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        pio_clr = 1'b0;
        m0_chipselect = 1'b1; m0_write_n = 1'b0; m0_address = 2'd0; m0_writedata = 32'h1;
        m1_chipselect = 1'b1; m1_write_n = 1'b1; m1_address = 2'd0;
        #1;
        tests_run++;
        if ({m0_waitrequest, m1_waitrequest, pio_q} !== {2'b11, 32'h0}) begin
            tests_failed++;
            $display("FAIL rt_idle w0=%b w1=%b pio=%h want w=11 pio=0", m0_waitrequest, m1_waitrequest, pio_q);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({m0_waitrequest, m1_waitrequest, s_chipselect, s_write_n, s_writedata} !== {4'b0110, 32'h1}) begin
            tests_failed++;
            $display("FAIL rt_gnt0 w0=%b w1=%b cs=%b wn=%b wd=%h want w0=0 w1=1 cs=1 wn=0 wd=1",
                     m0_waitrequest, m1_waitrequest, s_chipselect, s_write_n, s_writedata);
        end
        @(negedge clk);
        m0_chipselect = 1'b0; m0_write_n = 1'b1;
        #1;
        tests_run++;
        if ({m0_waitrequest, m1_waitrequest, m1_readdata} !== {2'b10, 32'h1}) begin
            tests_failed++;
            $display("FAIL rt_gnt1 w0=%b w1=%b rd1=%h want w0=1 w1=0 rd1=1", m0_waitrequest, m1_waitrequest, m1_readdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if ({m0_waitrequest, m1_waitrequest, s_chipselect} !== 3'b110) begin
            tests_failed++;
            $display("FAIL rt_end w0=%b w1=%b cs=%b want 110", m0_waitrequest, m1_waitrequest, s_chipselect);
        end
        $display("[TB] reset_tie: m1 read %h", m1_readdata);
    endtask

    task automatic test_back_to_back();
        int rem0 = 6, rem1 = 6, cyc = 0, accesses = 0, bad = 0;
        int stall0 = 0, stall1 = 0, max0 = 0, max1 = 0, prev = 2, g;
        while ((rem0 > 0 || rem1 > 0) && cyc < 40) begin
            @(negedge clk);
            m0_chipselect = (rem0 > 0); m0_write_n = 1'b0; m0_address = 2'd1;
            m0_writedata = 32'h100 + 32'(6 - rem0);
            m1_chipselect = (rem1 > 0); m1_write_n = 1'b1; m1_address = 2'd0;
            #1;
            g = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
            if (g == 0) begin
                tests_run++;
                if ({s_chipselect, s_write_n, s_address, s_writedata} !== {2'b10, 2'd1, 32'h100 + 32'(6 - rem0)}) begin
                    tests_failed++;
                    $display("FAIL b2b_m0 cyc=%0d cs=%b wn=%b addr=%h wd=%h want cs=1 wn=0 addr=1 wd=%h",
                             cyc, s_chipselect, s_write_n, s_address, s_writedata, 32'h100 + 32'(6 - rem0));
                end
                rem0--; accesses++; stall0 = 0;
            end else if (g == 1) begin
                tests_run++;
                if ({s_chipselect, s_write_n, m1_readdata} !== {2'b11, 32'h1}) begin
                    tests_failed++;
                    $display("FAIL b2b_m1 cyc=%0d cs=%b wn=%b rd1=%h want cs=1 wn=1 rd1=1",
                             cyc, s_chipselect, s_write_n, m1_readdata);
                end
                rem1--; accesses++; stall1 = 0;
            end
            if (m0_chipselect && m0_waitrequest) stall0++;
            if (m1_chipselect && m1_waitrequest) stall1++;
            if (stall0 > max0) max0 = stall0;
            if (stall1 > max1) max1 = stall1;
            if ((g == 2 && cyc > 0) || (g != 2 && g == prev)) bad++;
            prev = g;
            cyc++;
        end
        @(negedge clk);
        idle_inputs();
        tests_run++;
        if (cyc != 13 || accesses != 12) begin
            tests_failed++;
            $display("FAIL b2b_count cycles=%0d accesses=%0d want cycles=13 accesses=12", cyc, accesses);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_alternate bad_cycles=%0d want 0", bad);
        end
        tests_run++;
        if (max0 != 1 || max1 != 2) begin
            tests_failed++;
            $display("FAIL b2b_stall max0=%0d max1=%0d want max0=1 max1=2", max0, max1);
        end
        $display("[TB] back_to_back: %0d accesses in %0d cycles", accesses, cyc);
    endtask

    task automatic test_lock();
        logic [31:0] d1 [3];
        logic        l1 [3];
        int          exp_g [7];
        int          i1 = 0, g;
        bit          m0_done = 1'b0;
        d1[0] = 32'h0; d1[1] = 32'h1; d1[2] = 32'h0;
        l1[0] = 1'b1;  l1[1] = 1'b1;  l1[2] = 1'b0;
`ifdef LED_ARB_LOCK_EN
        exp_g[0] = 2; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1; exp_g[4] = 0; exp_g[5] = 2; exp_g[6] = 2;
`else
        exp_g[0] = 2; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1; exp_g[4] = 2; exp_g[5] = 1; exp_g[6] = 2;
`endif
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            m1_chipselect = (i1 < 3); m1_write_n = 1'b0; m1_address = 2'd0;
            m1_writedata  = (i1 < 3) ? d1[i1] : 32'h0;
            m1_lock       = (i1 < 3) ? l1[i1] : 1'b0;
            m0_chipselect = (c >= 1) && !m0_done; m0_write_n = 1'b0; m0_address = 2'd1; m0_writedata = 32'hAA;
            #1;
            g = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
            tests_run++;
            if (g != exp_g[c]) begin
                tests_failed++;
                $display("FAIL lock_seq cycle=%0d grant=%0d want=%0d (2=none)", c, g, exp_g[c]);
            end
            if (g == 0) m0_done = 1'b1;
            if (g == 1) i1++;
        end
        idle_inputs();
        tests_run++;
        if (pio_q !== 32'h0) begin
            tests_failed++;
            $display("FAIL lock_pio got=%h want=0", pio_q);
        end
        $display("[TB] lock: done");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        m1_chipselect = 1'b1; m1_write_n = 1'b0; m1_address = 2'd0; m1_writedata = 32'h1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({s_chipselect, s_write_n, m1_waitrequest} !== 3'b100) begin
            tests_failed++;
            $display("FAIL abort_grant cs=%b wn=%b w1=%b want 100", s_chipselect, s_write_n, m1_waitrequest);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({s_chipselect, s_write_n, m1_waitrequest, m1_readdata} !== {3'b011, 32'h0}) begin
            tests_failed++;
            $display("FAIL abort_async cs=%b wn=%b w1=%b rd1=%h want cs=0 wn=1 w1=1 rd1=0",
                     s_chipselect, s_write_n, m1_waitrequest, m1_readdata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (pio_q !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_pio got=%h want=0", pio_q);
        end
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({s_chipselect, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
            tests_failed++;
            $display("FAIL abort_release cs=%b w0=%b w1=%b want 011", s_chipselect, m0_waitrequest, m1_waitrequest);
        end
        $display("[TB] reset_abort: pio=%h", pio_q);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        pio_clr      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_grant_no_cs();
        test_tie_last_gnt();
        test_reset_tie();
        test_back_to_back();
        test_lock();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
